// File: rtl/sim_pkg.sv
// rtl/sim_pkg.sv - shared defaults and helpers for the similarity arbiter
package sim_pkg;

  localparam int SIM_NREQ = 4;
  localparam int SIM_DW   = 8;
  localparam int SIM_LAT  = 3;

  localparam logic [SIM_DW-1:0] SIM_MAX = {SIM_DW{1'b1}};

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sim_arbiter_if.sv
// rtl/sim_arbiter_if.sv - request/response bundle between clients, arbiter and scorer
interface sim_arbiter_if
  import sim_pkg::*;
#(
  parameter int NREQ = SIM_NREQ,
  parameter int DW   = SIM_DW
);

  localparam int IW = id_width(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_op1;
  logic [NREQ*DW-1:0] req_op2;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IW-1:0]      rsp_id;
  logic [DW-1:0]      rsp_res;
  logic               busy;

  // Client / downstream side.
  modport master (
    output req_valid, req_op1, req_op2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_res, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_op1, req_op2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_res, busy
  );

endinterface

// File: rtl/sim_arbiter_rr_arbiter.sv
// rtl/sim_arbiter_rr_arbiter.sv - round-robin grant with rotating priority pointer
module rr_arbiter
  import sim_pkg::*;
#(
  parameter int NREQ = SIM_NREQ,
  localparam int IW = id_width(NREQ)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] ptr;
  logic          found;

  function automatic int slot(input logic [IW-1:0] base, input int k);
    return (int'(base) + k) % NREQ;
  endfunction

  // First requester at or after the pointer wins, searching with wrap-around.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (enable && !found && req[slot(ptr, k)]) begin
        found                = 1'b1;
        grant[slot(ptr, k)]  = 1'b1;
        idx                  = IW'(slot(ptr, k));
      end
    end
  end

  // Pointer moves just past the winner only when the grant is actually taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/sim_arbiter.sv
// rtl/sim_arbiter.sv - shared similarity datapath with round-robin issue and credited output FIFO
module sim_arbiter
  import sim_pkg::*;
#(
  parameter int NREQ = SIM_NREQ,
  parameter int DW   = SIM_DW,
  parameter int LAT  = SIM_LAT
)(
  input  logic        clk,
  input  logic        rst,
  sim_arbiter_if.slave bus
);

  // FIFO depth covers every op that can be in flight plus one being drained.
  localparam int DEPTH = LAT + 1;
  localparam int IW    = id_width(NREQ);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam logic [DW-1:0] RES_MAX = {DW{1'b1}};

  logic [CW-1:0]   credit;
  logic [CW-1:0]   fifo_count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            enable;
  logic            issue;
  logic            pop;
  logic            fifo_empty;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic [DW-1:0]   sel_op1;
  logic [DW-1:0]   sel_op2;

  logic [LAT-1:0]  st_valid;
  logic [IW-1:0]   st_id [LAT];
  logic [DW-1:0]   s1_op1;
  logic [DW-1:0]   s1_op2;
  logic [DW-1:0]   abs_diff;
  logic [DW-1:0]   s1_res;
  logic            wr_en;
  logic [IW-1:0]   wr_id;
  logic [DW-1:0]   wr_res;

  logic [IW-1:0]   mem_id  [DEPTH];
  logic [DW-1:0]   mem_res [DEPTH];
  logic [IW-1:0]   held_id;
  logic [DW-1:0]   held_res;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full credit pool blocks issue even if a pop frees a slot this cycle.
  assign enable = rst && (credit < CW'(DEPTH));

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .enable  (enable),
    .advance (issue),
    .grant   (grant),
    .idx     (gidx)
  );

  assign bus.req_ready = grant;
  assign issue         = |(bus.req_valid & grant);
  assign sel_op1       = bus.req_op1[int'(gidx)*DW +: DW];
  assign sel_op2       = bus.req_op2[int'(gidx)*DW +: DW];

  // Valid/id shift chain plus the stage-1 operand registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_valid <= '0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      for (int i = 0; i < LAT; i++) st_id[i] <= '0;
    end else begin
      st_valid[0] <= issue;
      st_id[0]    <= gidx;
      s1_op1      <= sel_op1;
      s1_op2      <= sel_op2;
      for (int i = 1; i < LAT; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_id[i]    <= st_id[i-1];
      end
    end
  end

  // Absolute difference by unsigned compare, then distance from full scale.
  always_comb begin
    abs_diff = (s1_op1 > s1_op2) ? (s1_op1 - s1_op2) : (s1_op2 - s1_op1);
    s1_res   = RES_MAX - abs_diff;
  end

  generate
    if (LAT > 1) begin : g_res
      logic [DW-1:0] res_q [LAT-1];

      // Result registered at stage 2; later stages only delay it.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < LAT - 1; i++) res_q[i] <= '0;
        end else begin
          res_q[0] <= s1_res;
          for (int i = 1; i < LAT - 1; i++) res_q[i] <= res_q[i-1];
        end
      end

      assign wr_res = res_q[LAT-2];
    end else begin : g_nores
      assign wr_res = s1_res;
    end
  endgenerate

  assign wr_en      = st_valid[LAT-1];
  assign wr_id      = st_id[LAT-1];
  assign fifo_empty = (fifo_count == '0);
  assign pop        = !fifo_empty && bus.rsp_ready;

  // Credit, FIFO pointers/occupancy and the value shown while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit     <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      held_id    <= '0;
      held_res   <= '0;
    end else begin
      credit     <= credit + CW'(issue) - CW'(pop);
      fifo_count <= fifo_count + CW'(wr_en) - CW'(pop);
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      if (!fifo_empty) begin
        held_id  <= mem_id[rd_ptr];
        held_res <= mem_res[rd_ptr];
      end
    end
  end

  // FIFO storage; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_id[wr_ptr]  <= wr_id;
      mem_res[wr_ptr] <= wr_res;
    end
  end

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_id    = fifo_empty ? held_id  : mem_id[rd_ptr];
  assign bus.rsp_res   = fifo_empty ? held_res : mem_res[rd_ptr];
  assign bus.busy      = (credit != '0);

endmodule

// File: tb/tb_sim_arbiter.sv
// tb/tb_sim_arbiter.sv - randomized and directed checks of sim_arbiter against a queue model
module tb_sim_arbiter;
  import sim_pkg::*;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = LAT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sim_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
  sim_arbiter #(.NREQ(NREQ), .DW(DW), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  bit v_d [NREQ];
  int a_d [NREQ];
  int b_d [NREQ];
  bit rr_d;

  int m_ptr, m_credit, m_edge, m_held_id, m_held_res, m_gnt;
  bit m_pop;
  int inf_id[$], inf_res[$], inf_at[$], fq_id[$], fq_res[$];
  int obs_res[$], obs_id[$], gnt_log[$];
  int s_busy, s_rsp_valid, s_rsp_res, s_rsp_id, s_req_ready, s_edge;

  function automatic int sim_of(input int a, input int b);
    return ((1 << DW) - 1) - ((a > b) ? a - b : b - a);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_list(input string name, input int got[$], input int exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      check($sformatf("%s[%0d]", name, k), (k < got.size()) ? got[k] : -1, exp[k]);
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]          = v_d[i];
      bus.req_op1[i*DW +: DW]   = DW'(a_d[i]);
      bus.req_op2[i*DW +: DW]   = DW'(b_d[i]);
    end
    bus.rsp_ready = rr_d;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_credit = 0; m_held_id = 0; m_held_res = 0; m_gnt = -1; m_pop = 0;
    inf_id.delete(); inf_res.delete(); inf_at.delete(); fq_id.delete(); fq_res.delete();
  endtask

  task automatic sample_and_check();
    int g;
    g = -1;
    if (rst && m_credit < DEPTH)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v_d[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    check("req_ready", bus.req_ready, (g >= 0) ? (1 << g) : 0);
    check("rsp_valid", bus.rsp_valid, fq_id.size() > 0);
    check("rsp_id",    bus.rsp_id,  (fq_id.size() > 0) ? fq_id[0]  : m_held_id);
    check("rsp_res",   bus.rsp_res, (fq_id.size() > 0) ? fq_res[0] : m_held_res);
    check("busy",      bus.busy,    m_credit != 0);
    total++;
    assert (int'(dut.fifo_count) <= DEPTH) else begin
      bad++;
      $display("FAIL fifo_overflow: count %0d above %0d", dut.fifo_count, DEPTH);
    end
    m_gnt = g;
    m_pop = rst && (fq_id.size() > 0) && rr_d;
    s_busy = bus.busy; s_rsp_valid = bus.rsp_valid; s_rsp_res = bus.rsp_res;
    s_rsp_id = bus.rsp_id; s_req_ready = bus.req_ready; s_edge = m_edge;
    for (int i = 0; i < NREQ; i++)
      if (bus.req_ready[i] && bus.req_valid[i]) gnt_log.push_back(i);
    if (bus.rsp_valid && bus.rsp_ready) begin
      obs_res.push_back(bus.rsp_res);
      obs_id.push_back(bus.rsp_id);
    end
  endtask

  task automatic model_edge();
    m_edge++;
    if (fq_id.size() > 0) begin
      m_held_id  = fq_id[0];
      m_held_res = fq_res[0];
    end
    if (m_pop) begin
      void'(fq_id.pop_front());
      void'(fq_res.pop_front());
    end
    while (inf_at.size() > 0 && inf_at[0] == m_edge) begin
      void'(inf_at.pop_front());
      fq_id.push_back(inf_id.pop_front());
      fq_res.push_back(inf_res.pop_front());
    end
    if (m_gnt >= 0) begin
      inf_at.push_back(m_edge + LAT);
      inf_id.push_back(m_gnt);
      inf_res.push_back(sim_of(a_d[m_gnt], b_d[m_gnt]));
      m_ptr = (m_gnt + 1) % NREQ;
    end
    m_credit += ((m_gnt >= 0) ? 1 : 0) - (m_pop ? 1 : 0);
  endtask

  task automatic cycle();
    apply();
    @(negedge clk);
    sample_and_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_async();
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy",      bus.busy,      0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_id",    bus.rsp_id,    0);
    check("rst_rsp_res",   bus.rsp_res,   0);
  endtask

  task automatic do_reset();
    reset_async();
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NREQ; i++) begin
      v_d[i] = 1'b0; a_d[i] = 0; b_d[i] = 0;
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 40; n++) begin
      cycle();
      if (s_busy == 0 && m_credit == 0) break;
    end
    check({name, "_drained"}, s_busy, 0);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (!(v_d[i] && m_gnt != i)) begin
        v_d[i] = ($urandom_range(0, 99) < 50);
        a_d[i] = $urandom_range(0, 255);
        b_d[i] = $urandom_range(0, 255);
      end
    end
    rr_d = ($urandom_range(0, 99) < 65);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q[$];
    int issue_edge, lat_seen, ids;
    int pa[4], pb[4];

    clear_inputs();
    rr_d = 1'b0;
    m_edge = 0;
    model_reset();
    apply();
    #2;
    do_reset();

    // single issue: 200 vs 50 -> 105, visible LAT edges after issue
    rr_d = 1'b1;
    v_d[0] = 1; a_d[0] = 200; b_d[0] = 50;
    cycle();
    check("t1_grant", s_req_ready, 1);
    issue_edge = m_edge;
    v_d[0] = 0;
    lat_seen = -1;
    for (int n = 0; n < 10 && lat_seen < 0; n++) begin
      cycle();
      if (s_rsp_valid != 0) begin
        lat_seen = s_edge - issue_edge;
        check("t1_res", s_rsp_res, 105);
        check("t1_id", s_rsp_id, 0);
      end
    end
    check("t1_latency", lat_seen, 3);
    cycle();
    check("t1_busy_after_pop", s_busy, 0);

    // equal and extreme operands
    do_reset();
    rr_d = 1'b1;
    obs_res.delete(); obs_id.delete();
    pa = '{77, 0, 255, 10};
    pb = '{77, 255, 0, 11};
    v_d[1] = 1;
    for (int k = 0; k < 4; k++) begin
      a_d[1] = pa[k]; b_d[1] = pb[k];
      cycle();
    end
    v_d[1] = 0;
    drain("t2");
    exp_q = '{255, 0, 0, 254};
    check_list("t2_res", obs_res, exp_q);

    // all requesters valid: rotating grants and matching response ids
    do_reset();
    rr_d = 1'b1;
    gnt_log.delete(); obs_id.delete(); obs_res.delete();
    for (int i = 0; i < NREQ; i++) begin
      v_d[i] = 1; a_d[i] = $urandom_range(0, 255); b_d[i] = $urandom_range(0, 255);
    end
    for (int n = 0; n < 30 && gnt_log.size() < 6; n++) cycle();
    clear_inputs();
    exp_q = '{0, 1, 2, 3, 0, 1};
    check_list("t3_grants", gnt_log, exp_q);
    drain("t3");
    check_list("t3_ids", obs_id, exp_q);

    // backpressure: credit stops issue at DEPTH, one pop frees one slot next cycle
    do_reset();
    rr_d = 1'b0;
    gnt_log.delete(); obs_id.delete(); obs_res.delete();
    v_d[2] = 1; a_d[2] = $urandom_range(0, 255); b_d[2] = $urandom_range(0, 255);
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (m_gnt == 2) begin
        a_d[2] = $urandom_range(0, 255); b_d[2] = $urandom_range(0, 255);
      end
    end
    check("t4_issues", gnt_log.size(), 4);
    check("t4_stalled", s_req_ready, 0);
    rr_d = 1'b1;
    cycle();
    check("t4_no_reuse", s_req_ready, 0);
    rr_d = 1'b0;
    cycle();
    check("t4_resume", gnt_log.size(), 5);
    check("t4_one_pop", obs_res.size(), 1);
    v_d[2] = 0;
    rr_d = 1'b1;
    drain("t4");
    check("t4_all_out", obs_res.size(), 5);
    ids = 0;
    foreach (obs_id[k]) ids += obs_id[k];
    check("t4_id_sum", ids, 10);

    // wrap-around with only requesters 1 and 3, pointer parked at 2
    do_reset();
    rr_d = 1'b1;
    v_d[1] = 1; a_d[1] = 5; b_d[1] = 9;
    cycle();
    gnt_log.delete();
    v_d[3] = 1; a_d[3] = 100; b_d[3] = 1;
    for (int n = 0; n < 30 && gnt_log.size() < 3; n++) cycle();
    clear_inputs();
    exp_q = '{3, 1, 3};
    check_list("t5_grants", gnt_log, exp_q);
    drain("t5");

    // reset with two ops in flight and one buffered
    do_reset();
    rr_d = 1'b0;
    v_d[0] = 1;
    for (int k = 0; k < 3; k++) begin
      a_d[0] = 20 * k; b_d[0] = 3 * k;
      cycle();
    end
    v_d[0] = 0;
    cycle();
    check("t6_buffered", s_rsp_valid, 0);
    v_d[0] = 1;
    apply();
    reset_async();
    cycle();
    cycle();
    rst = 1'b1;
    v_d[0] = 0;
    rr_d = 1'b1;
    obs_res.delete(); obs_id.delete();
    for (int n = 0; n < 6; n++) cycle();
    check("t6_no_stale", obs_res.size(), 0);
    v_d[3] = 1; a_d[3] = 30; b_d[3] = 40;
    cycle();
    v_d[3] = 0;
    drain("t6");
    exp_q = '{245};
    check_list("t6_res", obs_res, exp_q);
    exp_q = '{3};
    check_list("t6_id", obs_id, exp_q);

    // randomized traffic with occasional mid-run reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      if ($urandom_range(0, 999) < 2) begin
        apply();
        reset_async();
        cycle();
        rst = 1'b1;
      end
      cycle();
    end
    clear_inputs();
    rr_d = 1'b1;
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
